// File: rtl/fp_norm_pkg.sv
// ---------------------------------------------------------------------------
// fp_norm_pkg
// Shared definitions for the FP mantissa normalisation path.
//   DEFAULT_WIDTH  : default operand width (mantissa + hidden bit + guard)
//   cnt_w()        : width needed to hold an index/count up to and including
//                    the operand width
//   norm_res_t     : normaliser result bundle consumed by the round stage
// ---------------------------------------------------------------------------
package fp_norm_pkg;

    localparam int DEFAULT_WIDTH = 25;

    // Counts must represent WIDTH itself (the lzc of a zero operand).
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int DEFAULT_CNT_W = cnt_w(DEFAULT_WIDTH);

    typedef struct packed {
        logic [DEFAULT_CNT_W-1:0] pos;
        logic [DEFAULT_CNT_W-1:0] lzc;
        logic [DEFAULT_WIDTH-1:0] norm;
        logic                     zero;
    } norm_res_t;

endpackage

// File: rtl/first1_norm_pipe_if.sv
// ---------------------------------------------------------------------------
// first1_norm_pipe_if
// Valid/ready bundle around the first-one normaliser.
//   in_data/in_valid/in_ready       : upstream operand handshake
//   out_pos/out_lzc/out_norm/out_zero/out_valid/out_ready : result handshake
//   out_tzc/out_sticky              : only with FIRST1_TRAIL_DET_EN defined
// Modports:
//   slave  : the normaliser's view (consumes operands, produces results)
//   master : the surrounding datapath's view
// ---------------------------------------------------------------------------
interface first1_norm_pipe_if
    import fp_norm_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = cnt_w(WIDTH)
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [CNT_W-1:0] out_pos;
    logic [CNT_W-1:0] out_lzc;
    logic [WIDTH-1:0] out_norm;
    logic             out_zero;
    logic             out_valid;
    logic             out_ready;
`ifdef FIRST1_TRAIL_DET_EN
    logic [CNT_W-1:0] out_tzc;
    logic             out_sticky;
`endif

    modport slave (
        input  in_data, in_valid, out_ready,
`ifdef FIRST1_TRAIL_DET_EN
        output out_tzc, out_sticky,
`endif
        output in_ready, out_pos, out_lzc, out_norm, out_zero, out_valid
    );

    modport master (
        output in_data, in_valid, out_ready,
`ifdef FIRST1_TRAIL_DET_EN
        input  out_tzc, out_sticky,
`endif
        input  in_ready, out_pos, out_lzc, out_norm, out_zero, out_valid
    );

endinterface

// File: rtl/first1_onehot_enc.sv
// ---------------------------------------------------------------------------
// first1_onehot_enc
// Combinational highest-set-bit detector, generic in WIDTH.
//   data   : operand
//   onehot : one-hot vector marking the highest set bit (all 0 if data==0)
//   pos    : binary index of that bit (0 if data==0)
//   zero   : data is all zeros
// Feeding a bit-reversed operand turns it into a lowest-set-bit detector.
// ---------------------------------------------------------------------------
module first1_onehot_enc
    import fp_norm_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = cnt_w(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] onehot,
    output logic [CNT_W-1:0] pos,
    output logic             zero
);

    // prefix[i] = |data[WIDTH-1:i]: set from the highest one downwards.
    logic [WIDTH-1:0] prefix;

    always_comb begin
        logic acc;
        // NOTE: every variable in a combinational block gets a default first,
        // so no path can leave it unassigned and infer a latch.
        acc    = 1'b0;
        prefix = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            acc       = acc | data[i];
            prefix[i] = acc;
        end
    end

    // Only the highest set bit sees a 1 in prefix with a 0 above it.
    assign onehot = prefix ^ {1'b0, prefix[WIDTH-1:1]};

    always_comb begin
        pos = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (onehot[i]) begin
                pos = pos | CNT_W'(i);
            end
        end
    end

    assign zero = ~prefix[0];

endmodule

// File: rtl/first1_norm_pipe.sv
// ---------------------------------------------------------------------------
// first1_norm_pipe
// Two-stage elastic first-one normaliser for FP mantissas.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : first1_norm_pipe_if.slave (operand in, result out)
// Stage 1 registers the operand with its one-hot MSB vector, encoded
// position and zero flag; stage 2 registers pos, lzc, the left-normalised
// operand and the zero flag. Latency 2, throughput 1, no bubble on refill.
// Optional build macro FIRST1_TRAIL_DET_EN adds out_tzc (trailing-zero
// count) and out_sticky (any set bit below the MSB), same latency.
// ---------------------------------------------------------------------------
module first1_norm_pipe
    import fp_norm_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = cnt_w(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    first1_norm_pipe_if.slave bus
);

    // ---------------- stall control ----------------
    logic s1_valid, s2_valid;
    logic stage1_adv, stage2_adv;

    assign stage2_adv   = ~s2_valid | bus.out_ready;
    assign stage1_adv   = ~s1_valid | stage2_adv;
    assign bus.in_ready = stage1_adv;

    // ---------------- stage 1: detect ----------------
    logic [WIDTH-1:0] det_onehot;
    logic [CNT_W-1:0] det_pos;
    logic             det_zero;

    first1_onehot_enc #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_lead_enc (
        .data   (bus.in_data),
        .onehot (det_onehot),
        .pos    (det_pos),
        .zero   (det_zero)
    );

    logic [WIDTH-1:0] s1_data;
    logic [WIDTH-1:0] s1_onehot;
    logic [CNT_W-1:0] s1_pos;
    logic             s1_zero;

`ifdef FIRST1_TRAIL_DET_EN
    logic [WIDTH-1:0] rev_data, rev_onehot, rev_back;
    logic [CNT_W-1:0] rev_pos;
    logic             rev_zero;
    logic [CNT_W-1:0] det_tzc;
    logic             det_sticky;

    always_comb begin
        rev_data = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rev_data[i] = bus.in_data[WIDTH-1-i];
        end
    end

    first1_onehot_enc #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_trail_enc (
        .data   (rev_data),
        .onehot (rev_onehot),
        .pos    (rev_pos),
        .zero   (rev_zero)
    );

    // Undo the reversal so the lowest-set-bit marker is in operand order.
    always_comb begin
        rev_back = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rev_back[i] = rev_onehot[WIDTH-1-i];
        end
    end

    // Highest reversed index r is original bit WIDTH-1-r, i.e. the tzc.
    assign det_tzc    = rev_zero ? CNT_W'(WIDTH) : CNT_W'(WIDTH - 1) - rev_pos;
    // Some bit below the MSB is set exactly when lowest and highest differ.
    assign det_sticky = (rev_back != det_onehot);

    logic [CNT_W-1:0] s1_tzc;
    logic             s1_sticky;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: data registers are reset too, so outputs read 0 during reset
        // rather than holding stale values from before it.
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_onehot <= '0;
            s1_pos    <= '0;
            s1_zero   <= 1'b0;
`ifdef FIRST1_TRAIL_DET_EN
            s1_tzc    <= '0;
            s1_sticky <= 1'b0;
`endif
        end else if (stage1_adv) begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_data   <= bus.in_data;
                s1_onehot <= det_onehot;
                s1_pos    <= det_pos;
                s1_zero   <= det_zero;
`ifdef FIRST1_TRAIL_DET_EN
                s1_tzc    <= det_tzc;
                s1_sticky <= det_sticky;
`endif
            end
        end
    end

    // ---------------- stage 2: shift ----------------
    logic [CNT_W-1:0] s1_lzc;
    assign s1_lzc = s1_zero ? CNT_W'(WIDTH) : CNT_W'(WIDTH - 1) - s1_pos;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid     <= 1'b0;
            bus.out_pos  <= '0;
            bus.out_lzc  <= '0;
            bus.out_norm <= '0;
            bus.out_zero <= 1'b0;
`ifdef FIRST1_TRAIL_DET_EN
            bus.out_tzc    <= '0;
            bus.out_sticky <= 1'b0;
`endif
        end else if (stage2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                bus.out_pos  <= s1_pos;
                bus.out_lzc  <= s1_lzc;
                bus.out_norm <= s1_data << s1_lzc;
                // The one-hot vector is empty exactly when the operand is zero.
                bus.out_zero <= ~|s1_onehot;
`ifdef FIRST1_TRAIL_DET_EN
                bus.out_tzc    <= s1_tzc;
                bus.out_sticky <= s1_sticky;
`endif
            end
        end
    end

    assign bus.out_valid = s2_valid;

endmodule

// File: tb/tb_first1_norm_pipe.sv
// ---------------------------------------------------------------------------
// tb_first1_norm_pipe
// Directed self-checking bench for first1_norm_pipe at WIDTH=25.
// ---------------------------------------------------------------------------
module tb_first1_norm_pipe;

    localparam int W  = 25;
    localparam int CW = 5;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    first1_norm_pipe_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    first1_norm_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and sample 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input int pos, input int lzc,
                             input int norm, input int zero);
        check({tag, ".valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, ".pos"},   64'(bus.out_pos),   64'(pos));
        check({tag, ".lzc"},   64'(bus.out_lzc),   64'(lzc));
        check({tag, ".norm"},  64'(bus.out_norm),  64'(norm));
        check({tag, ".zero"},  64'(bus.out_zero),  64'(zero));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, ".pos"},   64'(bus.out_pos),   64'd0);
        check({tag, ".lzc"},   64'(bus.out_lzc),   64'd0);
        check({tag, ".norm"},  64'(bus.out_norm),  64'd0);
        check({tag, ".zero"},  64'(bus.out_zero),  64'd0);
    endtask

    // One isolated item with out_ready=1: visible exactly two edges later.
    task automatic single(input string tag, input int data, input int pos,
                          input int lzc, input int norm, input int zero);
        bus.in_data  = W'(data);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check({tag, ".lat1"}, 64'(bus.out_valid), 64'd0);
        tick();
        check_out(tag, pos, lzc, norm, zero);
    endtask

    int k, first_i, last_i;

    initial begin
        rst_n         = 1'b0;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #2;
        check_all_zero("reset");
        check("reset.in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        rst_n = 1'b1;

        // ---- isolated vectors ----
        single("bit10",  32'h0000400,  10, 14, 32'h1000000, 0);
        single("zero",   32'h0000000,   0, 25, 32'h0000000, 1);
        single("allone", 32'h1FFFFFF,  24,  0, 32'h1FFFFFF, 0);
        single("bit0",   32'h0000001,   0, 24, 32'h1000000, 0);
        single("mix",    32'h0A5A5A5,  23,  1, 32'h14B4B4A, 0);
        tick();
        check("idle.valid", 64'(bus.out_valid), 64'd0);

        // ---- back-to-back walking one ----
        k = 0; first_i = -1; last_i = -1;
        for (int i = 0; i < 27; i++) begin
            if (i < 25) begin
                bus.in_data  = W'(1) << i;
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            tick();
            if (bus.out_valid) begin
                check_out("walk", k, 24 - k, 32'h1000000, 0);
                if (first_i < 0) first_i = i;
                last_i = i;
                k++;
            end
        end
        check("walk.count", 64'(k), 64'd25);
        check("walk.gap", 64'(last_i - first_i), 64'd24);

        // ---- backpressure: 5 cycles out_ready=0, 3 items offered ----
        bus.out_ready = 1'b0;
        bus.in_data   = W'(32'h0000100);
        bus.in_valid  = 1'b1;
        #1;
        check("bp.ready0", 64'(bus.in_ready), 64'd1);
        tick();
        check("bp.ready1", 64'(bus.in_ready), 64'd1);
        bus.in_data = W'(32'h0000003);
        tick();
        bus.in_data = W'(32'h0010000);
        #1;
        check("bp.ready2", 64'(bus.in_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("bp.hold", 8, 16, 32'h1000000, 0);
            check("bp.stall", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp.release", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        check_out("bp.b", 1, 23, 32'h1800000, 0);
        tick();
        check_out("bp.c", 16, 8, 32'h1000000, 0);
        tick();
        check("bp.drained", 64'(bus.out_valid), 64'd0);

        // ---- reset with two items in flight ----
        bus.in_data  = W'(32'h0000400);
        bus.in_valid = 1'b1;
        tick();
        bus.in_data  = W'(32'h0000001);
        tick();
        bus.in_valid = 1'b0;
        check("rst.inflight", 64'(bus.out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst.async");
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst.quiet", 64'(bus.out_valid), 64'd0);
        end
        single("rst.after", 32'h0000080, 7, 17, 32'h1000000, 0);

`ifdef FIRST1_TRAIL_DET_EN
        tick();
        single("trail.a00", 32'h0000A00, 11, 13, 32'h1400000, 0);
        check("trail.a00.tzc",    64'(bus.out_tzc),    64'd9);
        check("trail.a00.sticky", 64'(bus.out_sticky), 64'd1);
        tick();
        single("trail.800", 32'h0000800, 11, 13, 32'h1000000, 0);
        check("trail.800.tzc",    64'(bus.out_tzc),    64'd11);
        check("trail.800.sticky", 64'(bus.out_sticky), 64'd0);
        tick();
        single("trail.zero", 32'h0000000, 0, 25, 32'h0000000, 1);
        check("trail.zero.tzc",    64'(bus.out_tzc),    64'd25);
        check("trail.zero.sticky", 64'(bus.out_sticky), 64'd0);
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/first1_norm_pipe.md
Name: first1_norm_pipe

Overview:
- Parametrised, pipelined successor to the fixed 25-bit combinational first-one detector used in FP mantissa normalisation.
- Finds the most significant set bit of a WIDTH-bit operand. Returns its index and the leading-zero count, plus the operand left-shifted so its MSB is 1.
- Elastic valid/ready pipeline. Sits between the mantissa add/sub stage and the exponent-adjust/round stage of the FP adder.

Parameters:
- WIDTH, 25, operand width in bits (mantissa plus hidden bit plus guard). Legal range is 2 to 64.
- CNT_W, $clog2(WIDTH+1), width of the index and count outputs. It must be able to hold the value WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  WIDTH  operand to normalise.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  block accepts in_data this cycle.
- out_pos  out  CNT_W  index of the highest set bit; 0 when the operand is zero.
- out_lzc  out  CNT_W  leading-zero count, WIDTH-1-out_pos; equals WIDTH when the operand is zero.
- out_norm  out  WIDTH  in_data << out_lzc, so out_norm[WIDTH-1] is 1 unless the operand is zero.
- out_zero  out  1  operand was all zeros.
- out_valid  out  1  outputs are valid.
- out_ready  in  1  downstream accepts the outputs.

Behaviour:
- Reset (asynchronous assert, synchronous release): both stage valids are 0 and out_valid is 0. All data registers, and out_pos/out_lzc/out_norm/out_zero, are 0.
- Reset asserted mid-operation discards every in-flight item; nothing is emitted after release.
- Handshake:
  - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
  - out_valid and the output data stay stable while out_valid=1 and out_ready=0.
  - in_valid must not depend on in_ready.
- Stage 1 (detect), on input transfer:
  - Registers in_data and the one-hot highest-set-bit vector, built with the prefix-OR/XOR scheme generalised to WIDTH.
  - Also registers the encoded position and the zero flag.
- Stage 2 (shift): registers out_pos and out_lzc, out_norm = s1_data << lzc (barrel shift, zero fill), and out_zero.
- Latency is exactly 2 cycles from input transfer to out_valid when there is no backpressure. Throughput is 1 item per cycle.
- Stall rules:
  - stage2_adv = !s2_valid | out_ready.
  - stage1_adv = !s1_valid | stage2_adv.
  - in_ready = stage1_adv. It is combinational from out_ready; there is no bubble.
- Simultaneous output transfer and stage-1 refill in the same cycle is legal: stage 2 loads the new item and out_valid stays 1.
- Boundary values:
  - Zero input: pos 0, lzc WIDTH, norm 0, zero 1.
  - in_data[WIDTH-1]=1: pos WIDTH-1, lzc 0, norm = in_data.
  - Only bit 0 set: pos 0, lzc WIDTH-1, norm = 1<<(WIDTH-1).
- No item is dropped or duplicated under any valid/ready pattern.

Optional Feature:
- Macro FIRST1_TRAIL_DET_EN.
- When defined:
  - Adds output out_tzc (CNT_W), the trailing-zero count, equal to WIDTH for a zero operand.
  - Adds output out_sticky (1), the OR of the bits shifted past the low end of a hypothetical right-normalise, i.e. (in_data & ((1<<out_pos)-1)) != 0.
  - Both are computed in stage 1 and registered in stage 2 with the same latency, stall and reset rules (reset value 0).
- When undefined: these ports and their logic are absent, and all other behaviour is identical.

Decomposition:
- Shared package fp_norm_pkg holds:
  - the default WIDTH constant (25);
  - the CNT_W helper function;
  - typedef norm_res_t {pos, lzc, norm, zero}, used by the round stage.
- One sub-module, first1_onehot_enc: combinational WIDTH-generic prefix-OR → XOR one-hot → binary encoder, also used for the trailing detector with bit-reversed input.

Test Plan:
- WIDTH=25, out_ready=1: in_data=0x0000400 (bit 10 set) → 2 cycles later out_pos=10, out_lzc=14, out_norm=0x1000000, out_zero=0.
- in_data=0 → out_zero=1, out_lzc=25, out_pos=0, out_norm=0. Then in_data=0x1FFFFFF → out_lzc=0, out_norm=0x1FFFFFF.
- Back-to-back inputs 1, 2, 4 … 1<<24 with out_ready=1 → 25 outputs in order on consecutive cycles, with lzc 24 down to 0.
- Hold out_ready=0 for 5 cycles with 3 items offered → in_ready=0 after 2 items are accepted; the held output is stable; releasing out_ready drains the items in order with no loss or duplication.
- Assert rst_n=0 with 2 items in flight → out_valid=0 and all outputs 0 immediately (asynchronous); after release nothing is emitted until a new input arrives.
- With FIRST1_TRAIL_DET_EN, in_data=0x0000A00 → out_tzc=9, out_pos=11, out_sticky=1. For in_data=0x0000800, out_sticky=0.
